// File: rtl/control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcode/funct
// values, datapath mux selects, ALU operations and exception cause codes.
package control_pkg;

   typedef enum logic [4:0] {
      S_FETCH   = 5'd0,
      S_IR_WR   = 5'd1,
      S_DECODE  = 5'd2,
      S_ADD     = 5'd3,
      S_SUB     = 5'd4,
      S_AND     = 5'd5,
      S_ADDI    = 5'd6,
      S_WB_RD   = 5'd7,
      S_WB_RT   = 5'd8,
      S_ADDR    = 5'd9,
      S_MEM_RD  = 5'd10,
      S_MEM_WR  = 5'd11,
      S_WB_MEM  = 5'd12,
      S_BR_CMP  = 5'd13,
      S_BR_TAKE = 5'd14,
      S_JUMP    = 5'd15,
      S_EXC_EPC = 5'd16,
      S_EXC_RD  = 5'd17,
      S_EXC_JMP = 5'd18,
      S_RST_SP  = 5'd19
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;

   localparam logic [2:0] SRC_PC     = 3'd0;
   localparam logic [2:0] SRC_ALUOUT = 3'd1;
   localparam logic [2:0] SRC_EXCVEC = 3'd3;
   localparam logic       MEM_READ   = 1'b0;
   localparam logic       MEM_WRITE  = 1'b1;

   localparam logic [2:0] REGDST_RT = 3'd0;
   localparam logic [2:0] REGDST_RD = 3'd1;
   localparam logic [2:0] REGDST_SP = 3'd2;

   localparam logic [1:0] SRCA_PC = 2'd0;
   localparam logic [1:0] SRCA_A  = 2'd1;

   localparam logic [2:0] SRCB_B     = 3'd0;
   localparam logic [2:0] SRCB_FOUR  = 3'd1;
   localparam logic [2:0] SRCB_IMM   = 3'd2;
   localparam logic [2:0] SRCB_IMMSH = 3'd3;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_MDR    = 2'd1;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd2;
   localparam logic [1:0] PCSRC_JUMP   = 2'd3;

   localparam logic [2:0] M2R_ALUOUT = 3'd0;
   localparam logic [2:0] M2R_MDR    = 3'd1;
   localparam logic [2:0] M2R_CONST  = 3'd2;

   localparam logic [1:0] CAUSE_NONE   = 2'd0;
   localparam logic [1:0] CAUSE_OPCODE = 2'd1;
   localparam logic [1:0] CAUSE_OVF    = 2'd2;

   typedef struct packed {
      logic [2:0] src_addr;
      logic       mem_op;
      logic       write_mdr;
      logic       ir_write;
      logic       reg_write;
      logic       write_a;
      logic       write_b;
      logic       write_aluout;
      logic       epc_write;
      logic       pc_write;
      logic [2:0] reg_dst;
      logic [1:0] alu_src_a;
      logic [2:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_source;
      logic [2:0] mem_to_reg;
   } ctrl_t;

endpackage

// File: rtl/ctrl_wait_counter.sv
// Memory wait-state counter: runs 0..MEM_WAIT-1 while enabled, wraps to 0 on the last
// count; clear forces 0. first/last are decoded combinationally from the count.
module ctrl_wait_counter #(
   parameter int unsigned MEM_WAIT = 1,
   parameter int          CW       = $clog2(MEM_WAIT) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          enable,
   output logic [CW-1:0] cnt,
   output logic          first,
   output logic          last
);

   assign first = (cnt == '0);
   assign last  = (cnt == CW'(MEM_WAIT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= last ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore outputs decoded combinationally from the state
// register and wait counter; every output is forced low while reset is held.
module multicycle_ctrl
   import control_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 1,
   parameter bit          EXC_EN   = 1'b1,
   parameter bit          SP_INIT  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OpCode,
   input  logic [5:0] Func,
   input  logic       Overflow,
   input  logic       EQ,
   output logic [2:0] SrcAddressMem,
   output logic       MemOp,
   output logic       WriteMDR,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       WriteA,
   output logic       WriteB,
   output logic       WriteALUOut,
   output logic       EPCWrite,
   output logic       PCWrite,
   output logic [2:0] RegDst,
   output logic [1:0] ALUSrcA,
   output logic [2:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [2:0] MemToReg,
   output logic [1:0] ExcCause,
   output logic [4:0] State
);

   localparam int     CW          = $clog2(MEM_WAIT) + 1;
   localparam state_t RESET_STATE = SP_INIT ? S_RST_SP : S_FETCH;

   state_t        state, next_state;
   logic [1:0]    cause, cause_nxt;
   logic [CW-1:0] cnt;
   logic          cnt_first, cnt_last, mem_state;
   ctrl_t         ctl, ctl_out;

   ctrl_wait_counter #(.MEM_WAIT(MEM_WAIT), .CW(CW)) u_wait (
      .clk    (clk),
      .reset  (reset),
      .clear  (!mem_state),
      .enable (mem_state),
      .cnt    (cnt),
      .first  (cnt_first),
      .last   (cnt_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RESET_STATE;
         cause <= CAUSE_NONE;
      end else begin
         state <= next_state;
         cause <= cause_nxt;
      end
   end

   always_comb begin
      next_state = S_FETCH;
      cause_nxt  = cause;
      mem_state  = 1'b0;
      ctl        = '0;
      case (state)
         S_RST_SP: begin
            ctl.reg_dst    = REGDST_SP;
            ctl.mem_to_reg = M2R_CONST;
            ctl.reg_write  = 1'b1;
         end
         S_FETCH: begin
            mem_state    = 1'b1;
            ctl.src_addr = SRC_PC;
            ctl.mem_op   = MEM_READ;
            // PC advances once per fetch, however long the read is held
            if (cnt_first) begin
               ctl.pc_write  = 1'b1;
               ctl.alu_src_a = SRCA_PC;
               ctl.alu_src_b = SRCB_FOUR;
               ctl.alu_op    = ALU_ADD;
               ctl.pc_source = PCSRC_ALU;
            end
            ctl.write_mdr = cnt_last;
            next_state    = cnt_last ? S_IR_WR : S_FETCH;
         end
         S_IR_WR: begin
            ctl.ir_write = 1'b1;
            next_state   = S_DECODE;
         end
         S_DECODE: begin
            ctl.write_a      = 1'b1;
            ctl.write_b      = 1'b1;
            ctl.alu_src_a    = SRCA_PC;
            ctl.alu_src_b    = SRCB_IMMSH;
            ctl.alu_op       = ALU_ADD;
            ctl.write_aluout = 1'b1;
            case (OpCode)
               OP_RTYPE: begin
                  case (Func)
                     FN_ADD:  next_state = S_ADD;
                     FN_SUB:  next_state = S_SUB;
                     FN_AND:  next_state = S_AND;
                     default: next_state = EXC_EN ? S_EXC_EPC : S_FETCH;
                  endcase
               end
               OP_ADDI:       next_state = S_ADDI;
               OP_LW, OP_SW:  next_state = S_ADDR;
               OP_BEQ, OP_BNE: next_state = S_BR_CMP;
               OP_J:          next_state = S_JUMP;
               default:       next_state = EXC_EN ? S_EXC_EPC : S_FETCH;
            endcase
            if (EXC_EN && next_state == S_EXC_EPC) cause_nxt = CAUSE_OPCODE;
         end
         S_ADD, S_SUB, S_AND, S_ADDI, S_ADDR: begin
            ctl.alu_src_a    = SRCA_A;
            ctl.alu_src_b    = (state == S_ADDI || state == S_ADDR) ? SRCB_IMM : SRCB_B;
            ctl.alu_op       = (state == S_SUB) ? ALU_SUB : (state == S_AND) ? ALU_AND : ALU_ADD;
            ctl.write_aluout = 1'b1;
            case (state)
               S_ADDR:  next_state = (OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
               S_AND:   next_state = S_WB_RD;
               S_ADDI:  next_state = S_WB_RT;
               default: next_state = S_WB_RD;
            endcase
            // the trap overrides write-back, so a faulting result never reaches the register file
            if (EXC_EN && Overflow && (state == S_ADD || state == S_SUB || state == S_ADDI)) begin
               next_state = S_EXC_EPC;
               cause_nxt  = CAUSE_OVF;
            end
         end
         S_WB_RD, S_WB_RT: begin
            ctl.reg_dst    = (state == S_WB_RD) ? REGDST_RD : REGDST_RT;
            ctl.mem_to_reg = M2R_ALUOUT;
            ctl.reg_write  = 1'b1;
         end
         S_MEM_RD, S_MEM_WR: begin
            mem_state     = 1'b1;
            ctl.src_addr  = SRC_ALUOUT;
            ctl.mem_op    = (state == S_MEM_WR) ? MEM_WRITE : MEM_READ;
            ctl.write_mdr = cnt_last && (state == S_MEM_RD);
            if (!cnt_last)              next_state = state;
            else if (state == S_MEM_RD) next_state = S_WB_MEM;
            else                        next_state = S_FETCH;
         end
         S_WB_MEM: begin
            ctl.reg_dst    = REGDST_RT;
            ctl.mem_to_reg = M2R_MDR;
            ctl.reg_write  = 1'b1;
         end
         S_BR_CMP: begin
            ctl.alu_src_a = SRCA_A;
            ctl.alu_src_b = SRCB_B;
            ctl.alu_op    = ALU_SUB;
            if ((OpCode == OP_BEQ && EQ) || (OpCode == OP_BNE && !EQ)) next_state = S_BR_TAKE;
         end
         S_BR_TAKE: begin
            ctl.pc_source = PCSRC_ALUOUT;
            ctl.pc_write  = 1'b1;
         end
         S_JUMP: begin
            ctl.pc_source = PCSRC_JUMP;
            ctl.pc_write  = 1'b1;
         end
         S_EXC_EPC: begin
            ctl.alu_src_a = SRCA_PC;
            ctl.alu_src_b = SRCB_FOUR;
            ctl.alu_op    = ALU_SUB;
            ctl.epc_write = 1'b1;
            next_state    = S_EXC_RD;
         end
         S_EXC_RD: begin
            mem_state     = 1'b1;
            ctl.src_addr  = SRC_EXCVEC;
            ctl.mem_op    = MEM_READ;
            ctl.write_mdr = cnt_last;
            next_state    = cnt_last ? S_EXC_JMP : S_EXC_RD;
         end
         S_EXC_JMP: begin
            ctl.pc_source = PCSRC_MDR;
            ctl.pc_write  = 1'b1;
         end
         default: next_state = S_FETCH;
      endcase
   end

   assign ctl_out = reset ? ctl : '0;

   assign SrcAddressMem = ctl_out.src_addr;
   assign MemOp         = ctl_out.mem_op;
   assign WriteMDR      = ctl_out.write_mdr;
   assign IRWrite       = ctl_out.ir_write;
   assign RegWrite      = ctl_out.reg_write;
   assign WriteA        = ctl_out.write_a;
   assign WriteB        = ctl_out.write_b;
   assign WriteALUOut   = ctl_out.write_aluout;
   assign EPCWrite      = ctl_out.epc_write;
   assign PCWrite       = ctl_out.pc_write;
   assign RegDst        = ctl_out.reg_dst;
   assign ALUSrcA       = ctl_out.alu_src_a;
   assign ALUSrcB       = ctl_out.alu_src_b;
   assign ALUOp         = ctl_out.alu_op;
   assign PCSource      = ctl_out.pc_source;
   assign MemToReg      = ctl_out.mem_to_reg;
   assign ExcCause      = reset ? cause : CAUSE_NONE;
   assign State         = reset ? state : 5'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two configurations, each checked every cycle against an
// instruction-level model that expands each instruction into its expected output sequence.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic [2:0] src;
      logic       memop, wmdr, irw, regw, wa, wb, walu, epcw, pcw;
      logic [2:0] regdst;
      logic [1:0] srca;
      logic [2:0] srcb;
      logic [2:0] alu;
      logic [1:0] pcsrc;
      logic [2:0] m2r;
      logic [1:0] cause;
   } ov_t;

   logic       clk;
   logic       ra, rb;
   logic [5:0] OpCode, Func;
   logic       Overflow, EQ;

   logic [2:0] a_src, a_regdst, a_srcb, a_alu, a_m2r;
   logic [1:0] a_srca, a_pcsrc, a_cause;
   logic       a_memop, a_wmdr, a_irw, a_regw, a_wa, a_wb, a_walu, a_epcw, a_pcw;
   logic [4:0] a_state;
   logic [2:0] b_src, b_regdst, b_srcb, b_alu, b_m2r;
   logic [1:0] b_srca, b_pcsrc, b_cause;
   logic       b_memop, b_wmdr, b_irw, b_regw, b_wa, b_wb, b_walu, b_epcw, b_pcw;
   logic [4:0] b_state;
   ov_t        oa, ob;

   // A: three wait states, exceptions and $sp init on; B: two wait states, both off
   multicycle_ctrl #(.MEM_WAIT(3), .EXC_EN(1'b1), .SP_INIT(1'b1)) dut_a (
      .clk(clk), .reset(ra), .OpCode(OpCode), .Func(Func), .Overflow(Overflow), .EQ(EQ),
      .SrcAddressMem(a_src), .MemOp(a_memop), .WriteMDR(a_wmdr), .IRWrite(a_irw),
      .RegWrite(a_regw), .WriteA(a_wa), .WriteB(a_wb), .WriteALUOut(a_walu),
      .EPCWrite(a_epcw), .PCWrite(a_pcw), .RegDst(a_regdst), .ALUSrcA(a_srca),
      .ALUSrcB(a_srcb), .ALUOp(a_alu), .PCSource(a_pcsrc), .MemToReg(a_m2r),
      .ExcCause(a_cause), .State(a_state));

   multicycle_ctrl #(.MEM_WAIT(2), .EXC_EN(1'b0), .SP_INIT(1'b0)) dut_b (
      .clk(clk), .reset(rb), .OpCode(OpCode), .Func(Func), .Overflow(Overflow), .EQ(EQ),
      .SrcAddressMem(b_src), .MemOp(b_memop), .WriteMDR(b_wmdr), .IRWrite(b_irw),
      .RegWrite(b_regw), .WriteA(b_wa), .WriteB(b_wb), .WriteALUOut(b_walu),
      .EPCWrite(b_epcw), .PCWrite(b_pcw), .RegDst(b_regdst), .ALUSrcA(b_srca),
      .ALUSrcB(b_srcb), .ALUOp(b_alu), .PCSource(b_pcsrc), .MemToReg(b_m2r),
      .ExcCause(b_cause), .State(b_state));

   assign oa = {a_src, a_memop, a_wmdr, a_irw, a_regw, a_wa, a_wb, a_walu, a_epcw, a_pcw,
                a_regdst, a_srca, a_srcb, a_alu, a_pcsrc, a_m2r, a_cause};
   assign ob = {b_src, b_memop, b_wmdr, b_irw, b_regw, b_wa, b_wb, b_walu, b_epcw, b_pcw,
                b_regdst, b_srca, b_srcb, b_alu, b_pcsrc, b_m2r, b_cause};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   sel = 1'b0;
   logic [1:0] mcause [2];
   ov_t  exp_q [$];
   ov_t  bld [$];
   ov_t  got_v, exp_v;

   always @(negedge clk) begin
      cyc++;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         got_v = sel ? ob : oa;
         checks++;
         if (got_v !== exp_v) begin
            failures++;
            $display("FAIL cycle_outputs dut=%0d cyc=%0d got=%h required=%h", sel, cyc, got_v, exp_v);
         end
      end
   end

   task automatic chk(input string name, input int got, input int req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s got=%0d required=%0d", name, got, req);
      end
   endtask

   function automatic ov_t blank();
      ov_t v = '0;
      v.cause = mcause[sel];
      return v;
   endfunction

   task automatic mem_phase(input int mw, input logic [2:0] src, input bit wr, input bit fetch);
      ov_t v;
      for (int c = 0; c < mw; c++) begin
         v = blank(); v.src = src; v.memop = wr;
         if (fetch && c == 0) begin v.pcw = 1; v.srcb = 3'd1; v.alu = 3'd1; end
         if (!wr && c == mw - 1) v.wmdr = 1;
         bld.push_back(v);
      end
   endtask

   task automatic trap(input logic [1:0] c, input int mw);
      ov_t v;
      mcause[sel] = c;
      v = blank(); v.srcb = 3'd1; v.alu = 3'd2; v.epcw = 1; bld.push_back(v);
      mem_phase(mw, 3'd3, 1'b0, 1'b0);
      v = blank(); v.pcsrc = 2'd1; v.pcw = 1; bld.push_back(v);
   endtask

   // Expected per-cycle outputs of one whole instruction, fetch through retirement
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input bit ovf, input bit eq);
      int mw = sel ? 2 : 3;
      bit exc = !sel;
      bit arith = (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24));
      ov_t v;
      bld.delete();
      mem_phase(mw, 3'd0, 1'b0, 1'b1);
      v = blank(); v.irw = 1; bld.push_back(v);
      v = blank(); v.wa = 1; v.wb = 1; v.srcb = 3'd3; v.alu = 3'd1; v.walu = 1; bld.push_back(v);
      if (arith || op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
         v = blank(); v.srca = 2'd1; v.walu = 1;
         v.srcb = arith ? 3'd0 : 3'd2;
         v.alu = (fn == 6'h22 && arith) ? 3'd2 : (fn == 6'h24 && arith) ? 3'd3 : 3'd1;
         bld.push_back(v);
         if (exc && ovf && (op == 6'h08 || (arith && fn != 6'h24))) trap(2'd2, mw);
         else if (op == 6'h2B) mem_phase(mw, 3'd1, 1'b1, 1'b0);
         else if (op == 6'h23) begin
            mem_phase(mw, 3'd1, 1'b0, 1'b0);
            v = blank(); v.m2r = 3'd1; v.regw = 1; bld.push_back(v);
         end else begin
            v = blank(); v.regw = 1; v.regdst = arith ? 3'd1 : 3'd0; bld.push_back(v);
         end
      end else if (op == 6'h04 || op == 6'h05) begin
         v = blank(); v.srca = 2'd1; v.alu = 3'd2; bld.push_back(v);
         if ((op == 6'h04) == eq) begin
            v = blank(); v.pcsrc = 2'd2; v.pcw = 1; bld.push_back(v);
         end
      end else if (op == 6'h02) begin
         v = blank(); v.pcsrc = 2'd3; v.pcw = 1; bld.push_back(v);
      end else if (exc) trap(2'd1, mw);
   endtask

   task automatic run(input logic [5:0] op, input logic [5:0] fn, input bit ovf, input bit eq,
                      input int maxn);
      OpCode = op; Func = fn; Overflow = ovf; EQ = eq;
      build(op, fn, ovf, eq);
      for (int i = 0; i < bld.size() && (maxn < 0 || i < maxn); i++) exp_q.push_back(bld[i]);
   endtask

   task automatic wait_empty();
      int n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      if (exp_q.size() > 0) begin
         checks++; failures++;
         $display("FAIL wait_empty pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic push_zeros(input int n);
      mcause[sel] = 2'd0;
      for (int i = 0; i < n; i++) exp_q.push_back('0);
   endtask

   task automatic push_rst_sp();
      ov_t v = blank();
      v.regw = 1; v.regdst = 3'd2; v.m2r = 3'd2;
      exp_q.push_back(v);
   endtask

   task automatic instr(input logic [5:0] op, input logic [5:0] fn, input bit ovf, input bit eq);
      step();
      run(op, fn, ovf, eq, -1);
      wait_empty();
   endtask

   initial begin
      ra = 1'b0; rb = 1'b0;
      OpCode = 6'h00; Func = 6'h20; Overflow = 1'b0; EQ = 1'b0;
      mcause[0] = 2'd0; mcause[1] = 2'd0;

      // configuration A: reset, then reset again in the middle of an add
      push_zeros(3);
      wait_empty();
      chk("a_state_in_reset", int'(a_state), 0);
      chk("b_state_in_reset", int'(b_state), 0);
      step(); ra = 1'b1; push_rst_sp(); wait_empty();
      step(); run(6'h00, 6'h20, 1'b0, 1'b0, 5); wait_empty();
      step(); ra = 1'b0; push_zeros(3); wait_empty();
      step(); ra = 1'b1; push_rst_sp(); wait_empty();

      instr(6'h00, 6'h20, 1'b0, 1'b0);
      chk("add_len_mw3", bld.size(), 7);
      chk("rst_sp_plus_add_cycles", 1 + bld.size(), 8);
      instr(6'h00, 6'h22, 1'b0, 1'b0);
      instr(6'h00, 6'h24, 1'b1, 1'b0);
      instr(6'h08, 6'h00, 1'b0, 1'b0);
      instr(6'h00, 6'h20, 1'b1, 1'b0);
      chk("add_ovf_len_mw3", bld.size(), 11);
      chk("a_cause_ovf", int'(a_cause), 2);
      instr(6'h3F, 6'h00, 1'b0, 1'b0);
      chk("bad_op_len_mw3", bld.size(), 10);
      chk("a_cause_opcode", int'(a_cause), 1);
      instr(6'h04, 6'h00, 1'b0, 1'b1);
      chk("beq_taken_len", bld.size(), 7);
      instr(6'h05, 6'h00, 1'b0, 1'b1);
      chk("bne_not_taken_len", bld.size(), 6);
      instr(6'h04, 6'h00, 1'b0, 1'b0);
      instr(6'h02, 6'h00, 1'b0, 1'b0);
      instr(6'h00, 6'h2A, 1'b0, 1'b0);
      instr(6'h23, 6'h00, 1'b0, 1'b0);
      instr(6'h2B, 6'h00, 1'b0, 1'b0);
      instr(6'h08, 6'h00, 1'b1, 1'b0);
      chk("a_cause_addi_ovf", int'(a_cause), 2);

      // configuration B: no $sp init, no exceptions, two wait states
      step(); ra = 1'b0; sel = 1'b1; push_zeros(2); wait_empty();
      step(); rb = 1'b1; run(6'h23, 6'h00, 1'b0, 1'b0, -1); wait_empty();
      chk("lw_len_mw2", bld.size(), 8);
      instr(6'h2B, 6'h00, 1'b0, 1'b0);
      chk("sw_len_mw2", bld.size(), 7);
      instr(6'h3F, 6'h00, 1'b0, 1'b0);
      chk("b_cause_stays_none", int'(b_cause), 0);
      instr(6'h00, 6'h20, 1'b1, 1'b0);
      chk("b_add_ovf_len", bld.size(), 6);
      instr(6'h05, 6'h00, 1'b0, 1'b0);
      instr(6'h00, 6'h22, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
